// File: rtl/testport_pkg.sv
// Shared types and constants for the test-port capture path.
package testport_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } session_e;

  localparam logic [29:0] TEST_PORT_DEF = 30'hFF;
  localparam logic [31:0] BEGIN_SYM_DEF = 32'h00000168;
  localparam logic [31:0] END_SYM_DEF   = 32'hFFFFFD5D;

  // Little-endian bus word to readable (most significant byte first) order.
  function automatic logic [31:0] byte_swap32(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

endpackage

// File: rtl/testport_capture_sync_fifo.sv
// Single-clock FIFO. The pointers carry one extra wrap bit so that
// full and empty are told apart without a separate occupancy counter.
module sync_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer advance; the caller guarantees push is only raised when a slot is free
  // (or being freed by a pop in the same cycle).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop && !empty) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents need no reset because head is masked while empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/testport_capture.sv
// Snoops the data-memory write bus for test-port writes, collapses D-cache
// stall repeats into single captures, frames a BEGIN..END session and
// queues the captured words for the checker.
module testport_capture
  import testport_pkg::*;
#(
  parameter logic [29:0] TEST_PORT = TEST_PORT_DEF,
  parameter logic [31:0] BEGIN_SYM = BEGIN_SYM_DEF,
  parameter logic [31:0] END_SYM   = END_SYM_DEF,
  parameter int          DEPTH     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] addr,
  input  logic [31:0] data,
  input  logic        wen,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic        out_last,
  input  logic        out_ready,
  output logic [1:0]  session,
  output logic [15:0] word_cnt,
  output logic [7:0]  drop_cnt,
  output logic        overflow
);

  session_e    state_q, state_d;
  logic        armed_q, armed_d;
  logic [15:0] word_cnt_q, word_cnt_d;
  logic [7:0]  drop_cnt_q, drop_cnt_d;
  logic        overflow_q, overflow_d;

  logic        hit, capture, is_begin, is_end;
  logic [31:0] word;
  logic        push_req, push_acc, drop, pop, cnt_clr;
  logic        fifo_full, fifo_empty;
  logic [32:0] fifo_head;

  assign hit      = wen && (addr == TEST_PORT);
  assign capture  = hit && armed_q;
  assign word     = byte_swap32(data);
  assign is_begin = (word == BEGIN_SYM);
  assign is_end   = (word == END_SYM);

  assign pop      = out_valid && out_ready;
  assign push_acc = push_req && (!fifo_full || pop);
  assign drop     = push_req && fifo_full && !pop;

  // Session state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Session next state; only capture events move it, DONE is left only by reset.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (capture && is_begin) state_d = RUN;
      RUN:     if (capture && is_end)   state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Session outputs: push every word captured in RUN, clear the count on BEGIN.
  always_comb begin
    push_req = 1'b0;
    cnt_clr  = 1'b0;
    unique case (state_q)
      IDLE:    cnt_clr  = capture && is_begin;
      RUN:     push_req = capture;
      default: ;
    endcase
  end

  // Dedup flag plus word/drop counters; a dropped word still counts as pushed.
  always_comb begin
    armed_d    = armed_q;
    word_cnt_d = word_cnt_q;
    drop_cnt_d = drop_cnt_q;
    overflow_d = overflow_q;
    if (capture)   armed_d = 1'b0;
    else if (!wen) armed_d = 1'b1;
    if (cnt_clr) word_cnt_d = '0;
    else if (push_req && word_cnt_q != 16'hFFFF) word_cnt_d = word_cnt_q + 16'd1;
    if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  // Bookkeeping registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      armed_q    <= 1'b1;
      word_cnt_q <= '0;
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      armed_q    <= armed_d;
      word_cnt_q <= word_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  sync_fifo #(
    .WIDTH(33),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_acc),
    .push_data ({is_end, word}),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = fifo_empty ? 32'd0 : fifo_head[31:0];
  assign out_last  = fifo_empty ? 1'b0  : fifo_head[32];
  assign session   = state_q;
  assign word_cnt  = word_cnt_q;
  assign drop_cnt  = drop_cnt_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_testport_capture.sv
// Directed bench for testport_capture.
module tb_testport_capture;

  localparam logic [29:0] TP   = 30'hFF;
  localparam logic [31:0] BSYM = 32'h00000168;
  localparam logic [31:0] ESYM = 32'hFFFFFD5D;

  logic        clk = 1'b0;
  logic        rst;
  logic [29:0] addr;
  logic [31:0] data;
  logic        wen;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_last;
  logic        out_ready;
  logic [1:0]  session;
  logic [15:0] word_cnt;
  logic [7:0]  drop_cnt;
  logic        overflow;

  int n_pass  = 0;
  int n_total = 0;

  testport_capture #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .addr      (addr),
    .data      (data),
    .wen       (wen),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .session   (session),
    .word_cnt  (word_cnt),
    .drop_cnt  (drop_cnt),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] le(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // One-cycle write pulse of a readable-order word; outputs sampled after the capture edge.
  task automatic send(input logic [31:0] w, output logic v, output logic [31:0] d,
                      output logic l);
    addr = TP;
    data = le(w);
    wen  = 1'b1;
    tick();
    v = out_valid;
    d = out_data;
    l = out_last;
    wen = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  logic        v, l;
  logic [31:0] d;
  logic [31:0] seq [8];
  logic [31:0] drain [4];

  initial begin
    rst = 1'b1; addr = '0; data = '0; wen = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // reset state
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    check("rst_session", 32'(session), 32'd0);
    check("rst_word_cnt", 32'(word_cnt), 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);

    // idle filtering
    send(32'h11, v, d, l);
    check("idle_valid", 32'(out_valid), 32'd0);
    check("idle_session", 32'(session), 32'd0);
    send(BSYM, v, d, l);
    check("begin_valid", 32'(out_valid), 32'd0);
    check("begin_session", 32'(session), 32'd1);
    check("begin_word_cnt", 32'(word_cnt), 32'd0);

    // wrong address write in RUN is not a hit
    addr = 30'hFE; data = le(32'h99); wen = 1'b1;
    tick();
    wen = 1'b0;
    tick();
    check("wrong_addr_valid", 32'(out_valid), 32'd0);

    // stalled write: 5 cycles, data changing
    addr = TP;
    wen  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      data = le(32'hA1A2A300 + 32'(i));
      tick();
    end
    wen = 1'b0;
    tick();
    check("stall_word_cnt", 32'(word_cnt), 32'd1);
    check("stall_valid", 32'(out_valid), 32'd1);
    check("stall_data", out_data, 32'hA1A2A300);
    check("stall_last", 32'(out_last), 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("stall_single", 32'(out_valid), 32'd0);

    // overflow: 6 words into a 4-deep FIFO with no consumer
    for (int i = 0; i < 6; i++) send(32'hB0000000 + 32'(i), v, d, l);
    check("ovf_drop_cnt", 32'(drop_cnt), 32'd2);
    check("ovf_overflow", 32'(overflow), 32'd1);
    check("ovf_word_cnt", 32'(word_cnt), 32'd7);
    check("ovf_head", out_data, 32'hB0000000);
    // pop and push in the same cycle while full
    out_ready = 1'b1; addr = TP; data = le(32'hC0FFEE00); wen = 1'b1;
    tick();
    out_ready = 1'b0; wen = 1'b0;
    tick();
    check("popush_drop_cnt", 32'(drop_cnt), 32'd2);
    check("popush_word_cnt", 32'(word_cnt), 32'd8);
    check("popush_head", out_data, 32'hB0000001);
    drain[0] = 32'hB0000001; drain[1] = 32'hB0000002;
    drain[2] = 32'hB0000003; drain[3] = 32'hC0FFEE00;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain%0d_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("drain%0d_data", i), out_data, drain[i]);
      tick();
    end
    check("drain_empty", 32'(out_valid), 32'd0);

    // full sequence from a fresh session
    do_reset();
    check("rst2_overflow", 32'(overflow), 32'd0);
    check("rst2_drop_cnt", 32'(drop_cnt), 32'd0);
    check("rst2_session", 32'(session), 32'd0);
    seq[0] = BSYM; seq[1] = 32'd0; seq[2] = 32'd1; seq[3] = 32'd1;
    seq[4] = 32'd1; seq[5] = 32'd1; seq[6] = 32'd0; seq[7] = ESYM;
    out_ready = 1'b1;
    send(seq[0], v, d, l);
    check("seq_begin_valid", 32'(v), 32'd0);
    for (int i = 1; i < 8; i++) begin
      send(seq[i], v, d, l);
      check($sformatf("seq%0d_valid", i), 32'(v), 32'd1);
      check($sformatf("seq%0d_data", i), d, seq[i]);
      check($sformatf("seq%0d_last", i), 32'(l), (i == 7) ? 32'd1 : 32'd0);
    end
    check("seq_session", 32'(session), 32'd2);
    check("seq_word_cnt", 32'(word_cnt), 32'd7);

    // DONE lockout
    send(BSYM, v, d, l);
    check("done_begin_valid", 32'(v), 32'd0);
    send(32'h55, v, d, l);
    check("done_data_valid", 32'(v), 32'd0);
    check("done_session", 32'(session), 32'd2);
    check("done_word_cnt", 32'(word_cnt), 32'd7);

    // reset mid-session with 3 words queued
    do_reset();
    out_ready = 1'b0;
    send(BSYM, v, d, l);
    for (int i = 0; i < 3; i++) send(32'hD0 + 32'(i), v, d, l);
    check("mid_valid_pre", 32'(out_valid), 32'd1);
    check("mid_word_cnt_pre", 32'(word_cnt), 32'd3);
    rst = 1'b1;
    tick();
    check("mid_valid", 32'(out_valid), 32'd0);
    check("mid_session", 32'(session), 32'd0);
    check("mid_word_cnt", 32'(word_cnt), 32'd0);
    check("mid_data", out_data, 32'd0);
    rst = 1'b0;
    tick();
    check("mid_valid_after", 32'(out_valid), 32'd0);

    // drop counter saturates at 255
    send(BSYM, v, d, l);
    for (int i = 0; i < 262; i++) send(32'hE000 + 32'(i), v, d, l);
    check("sat_drop_cnt", 32'(drop_cnt), 32'd255);
    check("sat_word_cnt", 32'(word_cnt), 32'd262);
    check("sat_head", out_data, 32'hE000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
